cu_responder: RTL and testbench

- Control-unit end of the bus-and-tag interface; the responder counterpart to `channel`.
- Recognises its device address during selection, accepts a command and presents initial status.
- Moves data bytes with the `service_in`/`service_out` handshake, honours a channel stop (`command_out` in response to `service_in`), and presents ending status.
- Sits between the channel-side tag lines and a simple device-side byte interface; used as the device model in channel benches and as a real CU in the design.

---
 rtl/cu_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_cu_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_responder.sv
// rtl/cu_responder.sv - control-unit responder on the bus-and-tag channel interface
// Every output is a register; the comb block computes next values from the sampled tags.
module cu_responder #(
   parameter logic [7:0] ADDRESS = 8'h10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] bus_out,
   output logic [7:0] bus_in,
   input  logic       operational_out,
   input  logic       address_out,
   input  logic       hold_out,
   input  logic       select_out,
   input  logic       command_out,
   input  logic       service_out,
   input  logic       suppress_out,
   output logic       operational_in,
   output logic       request_in,
   output logic       select_in,
   output logic       address_in,
   output logic       status_in,
   output logic       service_in,
   input  logic       ready,
   input  logic [7:0] record_len,
   output logic [7:0] command,
   output logic       command_strobe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_strobe,
   output logic       connected
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_IN, S_CMD_WAIT, S_INIT_STATUS, S_INIT_ACK,
      S_DATA, S_DATA_ACK, S_STOP_ACK, S_ENDING, S_END_ACK
   } state_t;

   localparam logic [1:0] CLS_TEST = 2'b00;
   localparam logic [1:0] CLS_READ = 2'b10;
   localparam logic [1:0] CLS_CTRL = 2'b11;
   localparam logic [7:0] ST_UC    = 8'h40;
   localparam logic [7:0] ST_END   = 8'h30;

   state_t     state_q, state_d;
   logic [7:0] bus_in_q, bus_in_d;
   logic       op_in_q, op_in_d;
   logic       sel_in_q, sel_in_d;
   logic       addr_in_q, addr_in_d;
   logic       stat_in_q, stat_in_d;
   logic       svc_in_q, svc_in_d;
   logic [7:0] command_q, command_d;
   logic       cmd_strobe_q, cmd_strobe_d;
   logic       tx_ready_q, tx_ready_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_strobe_q, rx_strobe_d;
   logic [7:0] count_q, count_d;
   logic       ready_q, ready_d;

   wire unused_suppress = suppress_out;
   wire is_read = (command_q[1:0] == CLS_READ);

   always_comb begin
      state_d      = state_q;
      bus_in_d     = bus_in_q;
      op_in_d      = op_in_q;
      sel_in_d     = 1'b0;
      addr_in_d    = addr_in_q;
      stat_in_d    = stat_in_q;
      svc_in_d     = svc_in_q;
      command_d    = command_q;
      cmd_strobe_d = 1'b0;
      tx_ready_d   = 1'b0;
      rx_data_d    = rx_data_q;
      rx_strobe_d  = 1'b0;
      count_d      = count_q;
      ready_d      = ready_q;

      if (!operational_out) begin
         state_d   = S_IDLE;
         bus_in_d  = 8'h00;
         op_in_d   = 1'b0;
         addr_in_d = 1'b0;
         stat_in_d = 1'b0;
         svc_in_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (select_out && hold_out && address_out && bus_out == ADDRESS) begin
                  op_in_d   = 1'b1;
                  addr_in_d = 1'b1;
                  bus_in_d  = ADDRESS;
                  state_d   = S_ADDR_IN;
               end else begin
                  sel_in_d = select_out;
               end
            end
            S_ADDR_IN: if (command_out) begin
               command_d = bus_out;
               count_d   = record_len;
               ready_d   = ready;
               addr_in_d = 1'b0;
               bus_in_d  = 8'h00;
               state_d   = S_CMD_WAIT;
            end
            S_CMD_WAIT: if (!command_out) begin
               stat_in_d = 1'b1;
               bus_in_d  = ready_q ? 8'h00 : ST_UC;
               state_d   = S_INIT_STATUS;
            end
            S_INIT_STATUS: if (service_out) begin
               stat_in_d = 1'b0;
               bus_in_d  = 8'h00;
               state_d   = S_INIT_ACK;
            end
            S_INIT_ACK: if (!service_out) begin
               if (!ready_q || command_q[1:0] == CLS_TEST) begin
                  op_in_d  = 1'b0;
                  bus_in_d = 8'h00;
                  state_d  = S_IDLE;
               end else begin
                  cmd_strobe_d = 1'b1;
                  if (command_q[1:0] == CLS_CTRL || count_q == 8'd0) begin
                     stat_in_d = 1'b1;
                     bus_in_d  = ST_END;
                     state_d   = S_ENDING;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (svc_in_q) begin
                  // A stop answers our service_in in place of service_out: no byte moves.
                  if (command_out) begin
                     svc_in_d = 1'b0;
                     bus_in_d = 8'h00;
                     state_d  = S_STOP_ACK;
                  end else if (service_out) begin
                     if (is_read) begin
                        tx_ready_d = 1'b1;
                     end else begin
                        rx_data_d   = bus_out;
                        rx_strobe_d = 1'b1;
                     end
                     count_d  = count_q - 8'd1;
                     svc_in_d = 1'b0;
                     bus_in_d = 8'h00;
                     state_d  = S_DATA_ACK;
                  end
               end else if (!is_read) begin
                  svc_in_d = 1'b1;
               end else if (tx_valid) begin
                  svc_in_d = 1'b1;
                  bus_in_d = tx_data;
               end
            end
            S_DATA_ACK: if (!service_out) begin
               if (count_q == 8'd0) begin
                  stat_in_d = 1'b1;
                  bus_in_d  = ST_END;
                  state_d   = S_ENDING;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_STOP_ACK: if (!command_out) begin
               stat_in_d = 1'b1;
               bus_in_d  = ST_END;
               state_d   = S_ENDING;
            end
            S_ENDING: if (service_out) begin
               stat_in_d = 1'b0;
               bus_in_d  = 8'h00;
               state_d   = S_END_ACK;
            end
            S_END_ACK: if (!service_out) begin
               op_in_d  = 1'b0;
               bus_in_d = 8'h00;
               state_d  = S_IDLE;
            end
            default: begin
               op_in_d  = 1'b0;
               bus_in_d = 8'h00;
               state_d  = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         bus_in_q     <= 8'h00;
         op_in_q      <= 1'b0;
         sel_in_q     <= 1'b0;
         addr_in_q    <= 1'b0;
         stat_in_q    <= 1'b0;
         svc_in_q     <= 1'b0;
         command_q    <= 8'h00;
         cmd_strobe_q <= 1'b0;
         tx_ready_q   <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_strobe_q  <= 1'b0;
         count_q      <= 8'h00;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         bus_in_q     <= bus_in_d;
         op_in_q      <= op_in_d;
         sel_in_q     <= sel_in_d;
         addr_in_q    <= addr_in_d;
         stat_in_q    <= stat_in_d;
         svc_in_q     <= svc_in_d;
         command_q    <= command_d;
         cmd_strobe_q <= cmd_strobe_d;
         tx_ready_q   <= tx_ready_d;
         rx_data_q    <= rx_data_d;
         rx_strobe_q  <= rx_strobe_d;
         count_q      <= count_d;
         ready_q      <= ready_d;
      end
   end

   assign bus_in         = bus_in_q;
   assign operational_in = op_in_q;
   assign request_in     = 1'b0;
   assign select_in      = sel_in_q;
   assign address_in     = addr_in_q;
   assign status_in      = stat_in_q;
   assign service_in     = svc_in_q;
   assign command        = command_q;
   assign command_strobe = cmd_strobe_q;
   assign tx_ready       = tx_ready_q;
   assign rx_data        = rx_data_q;
   assign rx_strobe      = rx_strobe_q;
   assign connected      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cu_responder.sv
// tb/tb_cu_responder.sv - channel-side driver and device model around cu_responder
// Expected outcomes come from a per-command transaction model, not from the FSM.
module tb_cu_responder;

   localparam logic [7:0] ADDR = 8'h10;
   localparam int W_OPIN = 0, W_ADDR = 1, W_STAT = 2, W_SVC = 3, W_SVC_STAT = 4;

   logic       clk = 1'b0;
   logic       reset, operational_out, address_out, hold_out, select_out;
   logic       command_out, service_out, suppress_out, ready, tx_valid;
   logic [7:0] bus_out, record_len, tx_data;
   logic [7:0] bus_in, command, rx_data;
   logic       operational_in, request_in, select_in, address_in, status_in, service_in;
   logic       command_strobe, tx_ready, rx_strobe, connected;

   int tests = 0, fails = 0;
   int cs_cnt, tx_cnt, rx_cnt;
   logic [7:0] rx_q[$];
   logic [7:0] dev_bytes[8];
   int         dev_delays[8];
   logic [7:0] wbytes[8];
   int         dev_idx, dev_n, dev_delay;
   bit         dev_active;

   cu_responder #(.ADDRESS(ADDR)) dut (
      .clk(clk), .reset(reset), .bus_out(bus_out), .bus_in(bus_in),
      .operational_out(operational_out), .address_out(address_out), .hold_out(hold_out),
      .select_out(select_out), .command_out(command_out), .service_out(service_out),
      .suppress_out(suppress_out), .operational_in(operational_in), .request_in(request_in),
      .select_in(select_in), .address_in(address_in), .status_in(status_in),
      .service_in(service_in), .ready(ready), .record_len(record_len), .command(command),
      .command_strobe(command_strobe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_strobe(rx_strobe), .connected(connected)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One negedge: monitor strobes, then let the device present its next byte.
   task automatic step();
      @(negedge clk);
      if (command_strobe) cs_cnt++;
      if (rx_strobe) begin
         rx_cnt++;
         rx_q.push_back(rx_data);
      end
      if (tx_ready) begin
         tx_cnt++;
         dev_idx++;
         tx_valid = 1'b0;
         if (dev_idx < dev_n) dev_delay = dev_delays[dev_idx];
      end else if (dev_active && !tx_valid && dev_idx < dev_n) begin
         if (dev_delay > 0) dev_delay--;
         else begin
            tx_valid = 1'b1;
            tx_data  = dev_bytes[dev_idx];
         end
      end
   endtask

   function automatic logic sig(input int w);
      case (w)
         W_OPIN:  return operational_in;
         W_ADDR:  return address_in;
         W_STAT:  return status_in;
         W_SVC:   return service_in;
         default: return service_in | status_in;
      endcase
   endfunction

   task automatic wait_for(input int w, input logic v, input string tag);
      for (int i = 0; i < 200; i++) begin
         if (sig(w) === v) break;
         step();
      end
      chk(tag, {31'd0, sig(w)}, {31'd0, v});
   endtask

   task automatic setup_dev(input int rlen);
      cs_cnt = 0; tx_cnt = 0; rx_cnt = 0;
      rx_q.delete();
      dev_idx = 0; dev_n = rlen; dev_delay = dev_delays[0];
      tx_valid = 1'b0; dev_active = 1'b1;
      record_len = rlen[7:0];
   endtask

   task automatic connect(input logic [7:0] cmd, output logic [7:0] st);
      bus_out = ADDR; select_out = 1'b1; hold_out = 1'b1; address_out = 1'b1;
      wait_for(W_ADDR, 1'b1, "address_in_rise");
      chk("address_echo", bus_in, ADDR);
      chk("operational_in_up", operational_in, 1);
      address_out = 1'b0; bus_out = cmd; command_out = 1'b1;
      wait_for(W_ADDR, 1'b0, "address_in_fall");
      command_out = 1'b0;
      wait_for(W_STAT, 1'b1, "init_status_tag");
      st = bus_in;
      service_out = 1'b1;
      wait_for(W_STAT, 1'b0, "init_status_drop");
      service_out = 1'b0;
   endtask

   task automatic release_channel();
      select_out = 1'b0; hold_out = 1'b0; address_out = 1'b0; bus_out = 8'h00;
      command_out = 1'b0; service_out = 1'b0;
      step(); step();
      dev_active = 1'b0; tx_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic [7:0] cmd, input bit rdy, input int rlen, input int ccount);
      logic [1:0] cls;
      logic [7:0] st;
      bit data_ph, exp_end;
      int exp_x, x;
      cls     = cmd[1:0];
      data_ph = rdy && (cls == 2'b01 || cls == 2'b10);
      exp_x   = data_ph ? ((rlen < ccount) ? rlen : ccount) : 0;
      exp_end = rdy && (cls != 2'b00);
      ready   = rdy;
      setup_dev(rlen);
      connect(cmd, st);
      chk("init_status", st, rdy ? 8'h00 : 8'h40);
      chk("command_latch", command, cmd);
      x = 0;
      if (exp_end) begin
         for (int it = 0; it < 20; it++) begin
            wait_for(W_SVC_STAT, 1'b1, "data_or_end_tag");
            if (status_in || !service_in) break;
            if (x >= ccount) begin
               command_out = 1'b1;
               wait_for(W_SVC, 1'b0, "stop_svc_drop");
               command_out = 1'b0;
            end else begin
               if (cls == 2'b10) chk("read_byte", bus_in, dev_bytes[x]);
               else bus_out = wbytes[x];
               service_out = 1'b1;
               wait_for(W_SVC, 1'b0, "data_svc_drop");
               service_out = 1'b0;
               x++;
            end
         end
         chk("ending_status", bus_in, 8'h30);
         service_out = 1'b1;
         wait_for(W_STAT, 1'b0, "ending_drop");
         service_out = 1'b0;
      end
      wait_for(W_OPIN, 1'b0, "disconnect");
      chk("connected_low", connected, 0);
      chk("xfer_count", x, exp_x);
      chk("command_strobes", cs_cnt, exp_end ? 1 : 0);
      chk("tx_ready_pulses", tx_cnt, (cls == 2'b10) ? exp_x : 0);
      chk("rx_strobe_pulses", rx_cnt, (cls == 2'b01) ? exp_x : 0);
      for (int i = 0; i < rx_q.size(); i++) chk("rx_byte", rx_q[i], wbytes[i]);
      release_channel();
   endtask

   task automatic abort_read(input bit use_reset);
      logic [7:0] st;
      ready = 1'b1;
      dev_bytes[0] = 8'h3C; dev_bytes[1] = 8'hC3; dev_delays[0] = 0; dev_delays[1] = 0;
      setup_dev(2);
      connect(8'h02, st);
      wait_for(W_SVC, 1'b1, "abort_svc_up");
      if (use_reset) reset = 1'b1; else operational_out = 1'b0;
      select_out = 1'b0; hold_out = 1'b0; address_out = 1'b0;
      step();
      chk("abort_tags", {operational_in, select_in, address_in, status_in, service_in}, 0);
      chk("abort_bus_in", bus_in, 8'h00);
      chk("abort_connected", connected, 0);
      chk("abort_tx_ready", tx_cnt, 0);
      if (use_reset) chk("reset_command", command, 8'h00);
      reset = 1'b0; operational_out = 1'b1;
      release_channel();
   endtask

   initial begin
      reset = 1'b1; operational_out = 1'b1; address_out = 1'b0; hold_out = 1'b0;
      select_out = 1'b0; command_out = 1'b0; service_out = 1'b0; suppress_out = 1'b0;
      ready = 1'b0; tx_valid = 1'b0; bus_out = 8'h00; record_len = 8'h00; tx_data = 8'h00;
      dev_active = 1'b0; dev_idx = 0; dev_n = 0; dev_delay = 0;
      cs_cnt = 0; tx_cnt = 0; rx_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         dev_bytes[i] = 8'h00; dev_delays[i] = 0; wbytes[i] = 8'h00;
      end
      step(); step();
      chk("reset_bus_in", bus_in, 8'h00);
      chk("reset_tags", {operational_in, request_in, select_in, address_in, status_in, service_in}, 0);
      chk("reset_strobes", {command_strobe, tx_ready, rx_strobe, connected}, 0);
      chk("reset_command", command, 8'h00);
      chk("reset_rx_data", rx_data, 8'h00);
      reset = 1'b0;
      step();

      // Selection of another device is propagated on select_in.
      bus_out = 8'h22; select_out = 1'b1; hold_out = 1'b1; address_out = 1'b1;
      step();
      chk("propagate_select", select_in, 1);
      chk("propagate_no_op", {operational_in, address_in}, 0);
      select_out = 1'b0;
      step();
      chk("propagate_drop", select_in, 0);
      release_channel();

      run_cmd(8'h00, 1'b1, 0, 0);
      wbytes[0] = 8'h02; wbytes[1] = 8'h01;
      run_cmd(8'h01, 1'b1, 3, 2);
      dev_bytes[0] = 8'hA5; dev_bytes[1] = 8'h5A; dev_delays[0] = 0; dev_delays[1] = 5;
      run_cmd(8'h02, 1'b1, 2, 5);
      run_cmd(8'h02, 1'b0, 2, 2);
      run_cmd(8'h03, 1'b1, 4, 4);
      run_cmd(8'h01, 1'b1, 0, 3);

      abort_read(1'b0);
      run_cmd(8'h00, 1'b1, 0, 0);
      abort_read(1'b1);
      run_cmd(8'h00, 1'b1, 0, 0);

      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < 8; i++) begin
            dev_bytes[i]  = 8'($urandom);
            wbytes[i]     = 8'($urandom);
            dev_delays[i] = $urandom_range(0, 6);
         end
         run_cmd(8'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, 4),
                 $urandom_range(0, 5));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
